// File: rtl/spi_msg_collector_pkg.sv
// Shared constants for the SPI input message collector family.
package spi_in_pkg;

    // Width of the outgoing message-length header field.
    localparam int LEN_FIELD_W    = 8;
    // Default clamp applied to the snapshotted message length.
    localparam int LEN_MAX_DEF    = 254;
    // Default idle timeout in system clock cycles.
    localparam int GFM_LIMIT_DEF  = 50000;
    // Back-pressure asserts when this many or fewer free slots remain.
    localparam int TX_STOP_MARGIN = 4;
    // Saturation value of the error counter.
    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

endpackage : spi_in_pkg

// File: rtl/spi_msg_collector_sync_fifo.sv
// Single-clock FIFO with registered read data and registered occupancy flags.
// Writes are gated by the fullness seen before any same-cycle read.
module sync_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       wr_en_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    input  logic                       rd_en_i,
    output logic [DATA_W-1:0]          rd_data_o,
    output logic [$clog2(DEPTH+1)-1:0] used_o,
    output logic [$clog2(DEPTH+1)-1:0] used_next_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int USED_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [USED_W-1:0] used_q, used_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              wr_ok_s, rd_ok_s;

    assign wr_ok_s = wr_en_i & ~full_q;
    assign rd_ok_s = rd_en_i & ~empty_q;

    // Next-state for pointers, occupancy and read data; pointers wrap modulo DEPTH.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        used_d    = used_q;
        rd_data_d = rd_data_q;
        if (wr_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_ok_s) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            rd_data_d = mem_q[rd_ptr_q];
        end else begin
            rd_ptr_d  = rd_ptr_q;
            rd_data_d = rd_data_q;
        end
        used_d  = used_q + USED_W'(wr_ok_s) - USED_W'(rd_ok_s);
        full_d  = (used_d == USED_W'(DEPTH));
        empty_d = (used_d == {USED_W{1'b0}});
    end

    // Storage array: written only on an accepted write, no reset needed.
    always_ff @(posedge clk_i) begin
        if (wr_ok_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Control and read-data registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q  <= {PTR_W{1'b0}};
            rd_ptr_q  <= {PTR_W{1'b0}};
            used_q    <= {USED_W{1'b0}};
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            rd_data_q <= {DATA_W{1'b0}};
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            used_q    <= used_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o   = rd_data_q;
    assign used_o      = used_q;
    assign used_next_o = used_d;
    assign full_o      = full_q;
    assign empty_o     = empty_q;

endmodule : sync_fifo

// File: rtl/spi_msg_collector.sv
// SPI-input message collector: oversampled deserialiser, FIFO buffering,
// idle/full-message flag, clamped length snapshot, overflow and error reporting.
// Optional feature macro: SPI_IN_PARITY_EN (adds a trailing even-parity bit per word).
module spi_msg_collector
    import spi_in_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 1024,
    parameter int MSG_WORDS   = 512,
    parameter int GFM_LIMIT   = GFM_LIMIT_DEF,
    parameter int LEN_MAX     = LEN_MAX_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   sys_clk_i,
    input  logic                   rst_ni,
    input  logic                   rx_clk_i,
    input  logic                   rx_data_i,
    input  logic                   rx_load_i,
    output logic                   tx_stop_o,
    input  logic                   rd_req_i,
    input  logic                   msg_start_i,
    output logic [DATA_W-1:0]      fifo_q_o,
    output logic                   fifo_empty_o,
    output logic                   got_full_msg_o,
    output logic [LEN_FIELD_W-1:0] msg_len_o,
    output logic                   overflow_o,
    output logic [7:0]             err_cnt_o
);

`ifdef SPI_IN_PARITY_EN
    localparam int WORD_LEN = DATA_W + 1;
`else
    localparam int WORD_LEN = DATA_W;
`endif
    localparam int CNT_W  = $clog2(WORD_LEN + 1);
    localparam int USED_W = $clog2(DEPTH + 1);
    localparam int TMR_W  = $clog2(GFM_LIMIT + 1);

`ifdef SPI_IN_PARITY_EN
    // A received word (data plus trailing parity bit) must have an even number of ones.
    function automatic logic parity_ok(input logic [WORD_LEN-1:0] w);
        return ~(^w);
    endfunction
`endif

    // Synchronisers and edge-detect history.
    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q, load_sync_q;
    logic                   clk_prev_q, load_prev_q;
    logic                   clk_s, data_s, load_s, clk_rise_s, load_fall_s;

    // Deserialiser state.
    logic [WORD_LEN-1:0] shift_q, shift_d, shift_next_s;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                wr_pend_q, wr_pend_d;
    logic [DATA_W-1:0]   wr_word_q, wr_word_d;
    logic                err_inc_s;

    // Flags, timer and status registers.
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic                   gfm_q, gfm_d;
    logic [LEN_FIELD_W-1:0] msg_len_q, msg_len_d;
    logic                   overflow_q, overflow_d;
    logic [7:0]             err_cnt_q, err_cnt_d;
    logic                   tx_stop_q, tx_stop_d;
    logic [31:0]            used_ext_s;

    // FIFO status.
    logic [USED_W-1:0] used_s, used_next_s;
    logic              full_s, empty_s;
    logic [DATA_W-1:0] rd_data_s;

    assign clk_s       = clk_sync_q[SYNC_STAGES-1];
    assign data_s      = data_sync_q[SYNC_STAGES-1];
    assign load_s      = load_sync_q[SYNC_STAGES-1];
    assign clk_rise_s  = clk_s & ~clk_prev_q;
    assign load_fall_s = load_prev_q & ~load_s;
    assign used_ext_s  = 32'(used_s);

    // Bring the asynchronous link inputs into the system clock domain.
    always_ff @(posedge sys_clk_i) begin
        if (!rst_ni) begin
            clk_sync_q  <= {SYNC_STAGES{1'b0}};
            data_sync_q <= {SYNC_STAGES{1'b0}};
            load_sync_q <= {SYNC_STAGES{1'b0}};
            clk_prev_q  <= 1'b0;
            load_prev_q <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], rx_clk_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], rx_data_i};
            load_sync_q <= {load_sync_q[SYNC_STAGES-2:0], rx_load_i};
            clk_prev_q  <= clk_s;
            load_prev_q <= load_s;
        end
    end

    // Deserialiser: shift MSB first, hand complete words to the FIFO one cycle later,
    // and flag framing (and parity) errors.
    always_comb begin
        shift_next_s = {shift_q[WORD_LEN-2:0], data_s};
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        wr_pend_d    = 1'b0;
        wr_word_d    = wr_word_q;
        err_inc_s    = 1'b0;
        if (load_fall_s) begin
            if (bit_cnt_q != {CNT_W{1'b0}}) begin
                err_inc_s = 1'b1;
                bit_cnt_d = {CNT_W{1'b0}};
            end else begin
                bit_cnt_d = bit_cnt_q;
            end
        end else if (clk_rise_s && load_s) begin
            shift_d = shift_next_s;
            if (bit_cnt_q == CNT_W'(WORD_LEN - 1)) begin
                bit_cnt_d = {CNT_W{1'b0}};
`ifdef SPI_IN_PARITY_EN
                if (parity_ok(shift_next_s)) begin
                    wr_pend_d = 1'b1;
                    wr_word_d = shift_next_s[WORD_LEN-1:1];
                end else begin
                    err_inc_s = 1'b1;
                end
`else
                wr_pend_d = 1'b1;
                wr_word_d = shift_next_s;
`endif
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end else begin
            shift_d = shift_q;
        end
    end

    // Idle timer, message-ready flag, length snapshot and status next-state.
    always_comb begin
        timer_d    = timer_q;
        gfm_d      = gfm_q;
        msg_len_d  = msg_len_q;
        overflow_d = overflow_q | (wr_pend_q & full_s);
        err_cnt_d  = err_cnt_q;
        tx_stop_d  = (used_next_s >= USED_W'(DEPTH - TX_STOP_MARGIN));

        if (rd_req_i) begin
            timer_d = {TMR_W{1'b0}};
        end else if (timer_q < TMR_W'(GFM_LIMIT)) begin
            timer_d = timer_q + TMR_W'(1);
        end else if (used_s != {USED_W{1'b0}}) begin
            timer_d = timer_q;
        end else begin
            timer_d = {TMR_W{1'b0}};
        end

        if (rd_req_i) begin
            gfm_d = 1'b0;
        end else if (((timer_q == TMR_W'(GFM_LIMIT)) && (used_s != {USED_W{1'b0}})) ||
                     (used_s >= USED_W'(MSG_WORDS))) begin
            gfm_d = 1'b1;
        end else begin
            gfm_d = gfm_q;
        end

        if (msg_start_i) begin
            if (used_ext_s > 32'(LEN_MAX)) begin
                msg_len_d = LEN_FIELD_W'(LEN_MAX);
            end else begin
                msg_len_d = used_ext_s[LEN_FIELD_W-1:0];
            end
        end else begin
            msg_len_d = msg_len_q;
        end

        if (err_inc_s && (err_cnt_q != ERR_CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State registers for deserialiser, timer and status outputs.
    always_ff @(posedge sys_clk_i) begin
        if (!rst_ni) begin
            shift_q    <= {WORD_LEN{1'b0}};
            bit_cnt_q  <= {CNT_W{1'b0}};
            wr_pend_q  <= 1'b0;
            wr_word_q  <= {DATA_W{1'b0}};
            timer_q    <= {TMR_W{1'b0}};
            gfm_q      <= 1'b0;
            msg_len_q  <= {LEN_FIELD_W{1'b0}};
            overflow_q <= 1'b0;
            err_cnt_q  <= 8'd0;
            tx_stop_q  <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            wr_pend_q  <= wr_pend_d;
            wr_word_q  <= wr_word_d;
            timer_q    <= timer_d;
            gfm_q      <= gfm_d;
            msg_len_q  <= msg_len_d;
            overflow_q <= overflow_d;
            err_cnt_q  <= err_cnt_d;
            tx_stop_q  <= tx_stop_d;
        end
    end

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i       (sys_clk_i),
        .rst_ni      (rst_ni),
        .wr_en_i     (wr_pend_q),
        .wr_data_i   (wr_word_q),
        .rd_en_i     (rd_req_i),
        .rd_data_o   (rd_data_s),
        .used_o      (used_s),
        .used_next_o (used_next_s),
        .full_o      (full_s),
        .empty_o     (empty_s)
    );

    assign fifo_q_o       = rd_data_s;
    assign fifo_empty_o   = empty_s;
    assign tx_stop_o      = tx_stop_q;
    assign got_full_msg_o = gfm_q;
    assign msg_len_o      = msg_len_q;
    assign overflow_o     = overflow_q;
    assign err_cnt_o      = err_cnt_q;

endmodule : spi_msg_collector
